sensor_conditioner: RTL and testbench
=====================================

# sensor_conditioner

Upstream front-end for the fuzzy flood-risk estimator. It accepts raw 8-bit ADC samples for rainfall and soil moisture over a valid/ready handshake, and keeps a per-channel moving average over a power-of-two window. Each average is scaled to the 0..100 percent range the estimator's membership functions expect. Each new conditioned pair is presented with a one-cycle strobe that drives the estimator's enable input, and a stale flag reports a dead sensor feed.

## Interface
- AVG_LOG2, 2: log2 of the averaging window; window N = 2^AVG_LOG2, legal range 1..4.
- TIMEOUT, 1024: cycles without an accepted sample before `stale` asserts; must be ≥ 2.
- MAX_PCT, 100: clamp ceiling for the scaled outputs.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard window history and return to FILL.
- in_valid  in  1  raw sample pair present.
- in_ready  out  1  block can accept a sample.
- raw_rain  in  8  rainfall ADC code, 0..255.
- raw_soil  in  8  soil-moisture ADC code, 0..255.
- out_rain  out  8  conditioned rainfall, 0..MAX_PCT.
- out_soil  out  8  conditioned soil moisture, 0..MAX_PCT.
- out_valid  out  1  one-cycle strobe, new conditioned pair; drives the estimator's enable.
- stale  out  1  no sample accepted for TIMEOUT cycles.

## Operation
- Reset values: in_ready=0, out_rain=0, out_soil=0, out_valid=0, stale=0. Reset also clears state to FILL, and clears the sums, ring buffers, fill count and timeout counter.
- in_ready=1 in every cycle after reset deasserts. It is 0 while rst=1 or flush=1.
- Accept = in_valid & in_ready.
- Each channel has an N-entry ring buffer, a write pointer that wraps modulo N, and a running sum of width 8+AVG_LOG2.
- On accept: sum ← sum + new − buf[wptr]; buf[wptr] ← new; wptr advances.
  - In FILL the evicted entries are zero, because the buffer is cleared.
- FSM, states FILL and RUN:
  - FILL → RUN on the accept that brings the fill count to N.
  - Any state → FILL on flush: buffers, sums, fill count and wptr are cleared.
- Scaling: avg = sum >> AVG_LOG2; pct = (avg × 101) >> 8, computed in 15 bits. Then out = min(pct, MAX_PCT).
  - Reference points: 0→0, 128→50, 255→100.
- out_valid pulses only for accepts whose evaluation ends in RUN, including the N-th accept. FILL accepts produce no strobe and do not change out_rain/out_soil.
- out_rain/out_soil hold their last value between strobes. flush does not clear them.
- Timeout counter:
  - Clears on every accept.
  - Otherwise increments, saturating at TIMEOUT.
  - stale=1 while the counter equals TIMEOUT.
  - stale clears in the cycle after the next accept.
- Simultaneous flush and in_valid: flush wins and the sample is dropped (in_ready=0). The timeout counter is not cleared.

## Timing
- Two-stage pipeline:
  - Stage 1 (accept edge): ring buffer and sum update.
  - Stage 2 (next edge): scale, clamp, register outputs and out_valid.
- Latency: out_valid and the new outputs appear 2 cycles after the accepting edge.
- Throughput: one sample per cycle. Back-to-back accepts give back-to-back strobes in RUN.
- A flush asserted while a stage-2 result is in flight suppresses that strobe.
- rst mid-operation takes effect at the next edge and overrides flush and in_valid.

## Structure
- Shared package `sensor_pkg`:
  - PCT_MAX constant (100).
  - ADC width constant (8).
  - FSM state enum {FILL, RUN}.
  - Scale multiplier constant (101).
- One natural sub-module, `ma_channel`: ring buffer, running sum and scale/clamp for one channel. Instantiate it twice; the FSM, handshake and timeout live in the top level.

## Test plan
- Reset, then four accepts of raw_rain=255, raw_soil=0 (N=4):
  - No strobe on accepts 1–3.
  - One strobe 2 cycles after accept 4, with out_rain=100, out_soil=0.
- Samples 0,0,0,128 on both channels → strobe with outputs 12 (avg 32, 3232>>8).
- Four samples of 200, then one sample of 0 → strobes with 78, then 59 (sum 600, avg 150).
- Flush together with in_valid after 2 accepts:
  - That sample is dropped and in_ready=0 for that cycle.
  - Four more accepts are needed before the next strobe.
  - Outputs hold their old values until then.
- TIMEOUT=16, idle after a strobe:
  - stale=1 exactly 16 cycles after the last accept.
  - stale clears one cycle after the next accept.
- Continuous in_valid=1 in RUN → out_valid high every cycle. Then rst for one cycle → all outputs 0 and FILL re-entered.

Source files
------------

// File: rtl/sensor_pkg.sv
`default_nettype none
// ============================================================================
// sensor_pkg : shared constants, FSM state type and percent scaling helper
// Revision   : 1.0
// ============================================================================
package sensor_pkg;

  localparam int PCT_MAX   = 100;
  localparam int ADC_W     = 8;
  localparam int SCALE_MUL = 101;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } cond_state_t;

  // avg * 101 / 256 maps 0..255 onto 0..100; the 15-bit product cannot overflow
  function automatic logic [ADC_W-1:0] scale_pct(input logic [ADC_W-1:0] avg,
                                                 input logic [ADC_W-1:0] ceil);
    logic [ADC_W-1:0] pct;
    pct = ADC_W'((15'(avg) * 15'(SCALE_MUL)) >> 8);
    return (pct > ceil) ? ceil : pct;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sensor_conditioner_if.sv
`default_nettype none
// ============================================================================
// sensor_conditioner_if : sample handshake, conditioned outputs and status
// Revision              : 1.0
// ============================================================================
interface sensor_conditioner_if;
  import sensor_pkg::*;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [ADC_W-1:0] raw_rain;
  logic [ADC_W-1:0] raw_soil;
  logic [ADC_W-1:0] out_rain;
  logic [ADC_W-1:0] out_soil;
  logic             out_valid;
  logic             stale;

  modport master (
    output flush, in_valid, raw_rain, raw_soil,
    input  in_ready, out_rain, out_soil, out_valid, stale
  );

  modport slave (
    input  flush, in_valid, raw_rain, raw_soil,
    output in_ready, out_rain, out_soil, out_valid, stale
  );

endinterface
`default_nettype wire

// File: rtl/sensor_conditioner_ma_channel.sv
`default_nettype none
// ============================================================================
// ma_channel : ring-buffer moving average with percent scaling for one channel
// Revision   : 1.0
// ============================================================================
module ma_channel
  import sensor_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int MAX_PCT  = PCT_MAX
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clear,
  input  wire logic             load,
  input  wire logic [ADC_W-1:0] sample,
  input  wire logic             capture,
  output logic      [ADC_W-1:0] value
);

  localparam int N     = 1 << AVG_LOG2;
  localparam int SUM_W = ADC_W + AVG_LOG2;

  logic [ADC_W-1:0]    r_ring [N];
  logic [AVG_LOG2-1:0] r_wptr;
  logic [SUM_W-1:0]    r_sum;
  logic [ADC_W-1:0]    w_avg;

  // the evicted entry is always part of the sum, so the subtraction never wraps
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_wptr <= '0;
      r_sum  <= '0;
      for (int i = 0; i < N; i++) begin
        r_ring[i] <= '0;
      end
    end else if (load) begin
      r_sum          <= r_sum + SUM_W'(sample) - SUM_W'(r_ring[r_wptr]);
      r_ring[r_wptr] <= sample;
      r_wptr         <= r_wptr + 1'b1;
    end
  end

  assign w_avg = r_sum[SUM_W-1:AVG_LOG2];

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (capture) begin
      value <= scale_pct(w_avg, ADC_W'(MAX_PCT));
    end
  end

endmodule
`default_nettype wire

// File: rtl/sensor_conditioner.sv
`default_nettype none
// ============================================================================
// sensor_conditioner : dual-channel moving average front-end with stale detect
// Revision           : 1.0
// ============================================================================
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT  = 1024,
  parameter int MAX_PCT  = PCT_MAX
) (
  input wire logic            clk,
  input wire logic            rst,
  sensor_conditioner_if.slave bus
);

  localparam int N      = 1 << AVG_LOG2;
  localparam int FILL_W = AVG_LOG2 + 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  cond_state_t       r_state;
  cond_state_t       w_next_state;
  logic [FILL_W-1:0] r_fill_cnt;
  logic [CNT_W-1:0]  r_idle;
  logic              r_pend;
  logic              r_out_valid;
  logic              w_ready;
  logic              w_accept;
  logic              w_last_fill;
  logic              w_eval_run;
  logic              w_fill_inc;
  logic              w_capture;

  assign w_ready     = ~rst & ~bus.flush;
  assign w_accept    = bus.in_valid & w_ready;
  assign w_last_fill = (r_fill_cnt == FILL_W'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (bus.flush) begin
      w_next_state = FILL;
    end else if (r_state == FILL && w_accept && w_last_fill) begin
      w_next_state = RUN;
    end
  end

  // the N-th fill accept already evaluates in RUN and therefore strobes
  always_comb begin
    w_eval_run = 1'b0;
    w_fill_inc = 1'b0;
    if (w_accept) begin
      w_eval_run = (r_state == RUN) || w_last_fill;
      w_fill_inc = (r_state == FILL);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_fill_cnt <= '0;
    end else if (w_fill_inc) begin
      r_fill_cnt <= r_fill_cnt + 1'b1;
    end
  end

  // a flush arriving while a result is in flight kills its strobe
  assign w_capture = r_pend & ~bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_pend      <= w_eval_run;
      r_out_valid <= w_capture;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_idle <= '0;
    end else if (r_idle != CNT_W'(TIMEOUT)) begin
      r_idle <= r_idle + 1'b1;
    end
  end

  ma_channel #(
    .AVG_LOG2 (AVG_LOG2),
    .MAX_PCT  (MAX_PCT)
  ) u_rain (
    .clk     (clk),
    .rst     (rst),
    .clear   (bus.flush),
    .load    (w_accept),
    .sample  (bus.raw_rain),
    .capture (w_capture),
    .value   (bus.out_rain)
  );

  ma_channel #(
    .AVG_LOG2 (AVG_LOG2),
    .MAX_PCT  (MAX_PCT)
  ) u_soil (
    .clk     (clk),
    .rst     (rst),
    .clear   (bus.flush),
    .load    (w_accept),
    .sample  (bus.raw_soil),
    .capture (w_capture),
    .value   (bus.out_soil)
  );

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.stale     = (r_idle == CNT_W'(TIMEOUT));

endmodule
`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// tb_sensor_conditioner : directed plus random stimulus against a queue model
// Revision              : 1.0
// ============================================================================
module tb_sensor_conditioner;

  localparam int AVG_LOG2 = 2;
  localparam int N        = 1 << AVG_LOG2;
  localparam int TMO      = 16;
  localparam int MAXP     = 100;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  sensor_conditioner_if bus ();

  sensor_conditioner #(
    .AVG_LOG2 (AVG_LOG2),
    .TIMEOUT  (TMO),
    .MAX_PCT  (MAXP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int hist_rain[$];
  int hist_soil[$];
  bit m_pend;
  int m_pend_rain;
  int m_pend_soil;
  int m_idle;
  bit e_valid;
  int e_rain;
  int e_soil;
  bit e_stale;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pct_of(input int vals[$]);
    int sum;
    int p;
    sum = 0;
    foreach (vals[i]) sum += vals[i];
    p = ((sum / N) * 101) / 256;
    return (p > MAXP) ? MAXP : p;
  endfunction

  task automatic model_reset();
    hist_rain.delete();
    hist_soil.delete();
    m_pend  = 1'b0;
    m_idle  = 0;
    e_valid = 1'b0;
    e_rain  = 0;
    e_soil  = 0;
    e_stale = 1'b0;
  endtask

  // predicts what is visible after the coming rising edge
  task automatic model_edge(input bit f, input bit v, input int r, input int s);
    bit acc;
    acc = v && !f;
    e_valid = m_pend && !f;
    if (e_valid) begin
      e_rain = m_pend_rain;
      e_soil = m_pend_soil;
    end
    if (f) begin
      m_pend = 1'b0;
      hist_rain.delete();
      hist_soil.delete();
    end else if (acc) begin
      hist_rain.push_back(r);
      hist_soil.push_back(s);
      if (hist_rain.size() > N) begin
        void'(hist_rain.pop_front());
        void'(hist_soil.pop_front());
      end
      m_pend = (hist_rain.size() == N);
      if (m_pend) begin
        m_pend_rain = pct_of(hist_rain);
        m_pend_soil = pct_of(hist_soil);
      end
    end else begin
      m_pend = 1'b0;
    end
    if (acc) m_idle = 0;
    else if (m_idle < TMO) m_idle++;
    e_stale = (m_idle == TMO);
  endtask

  // called just after a falling edge: drive, check ready, advance one cycle, check outputs
  task automatic cycle(input bit f, input bit v, input int r, input int s);
    bus.flush    = f;
    bus.in_valid = v;
    bus.raw_rain = 8'(r);
    bus.raw_soil = 8'(s);
    #1;
    chk("in_ready", int'(bus.in_ready), int'(!f));
    model_edge(f, v, r, s);
    @(posedge clk);
    @(negedge clk);
    chk("out_valid", int'(bus.out_valid), int'(e_valid));
    chk("out_rain", int'(bus.out_rain), e_rain);
    chk("out_soil", int'(bus.out_soil), e_soil);
    chk("stale", int'(bus.stale), int'(e_stale));
  endtask

  task automatic apply_reset();
    rst          = 1'b1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b1;
    bus.raw_rain = 8'd77;
    bus.raw_soil = 8'd77;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ready", int'(bus.in_ready), 0);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_rain", int'(bus.out_rain), 0);
    chk("rst_soil", int'(bus.out_soil), 0);
    chk("rst_stale", int'(bus.stale), 0);
    model_reset();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    model_reset();
    @(negedge clk);
    apply_reset();

    // fill with 255/0: strobe only after the 4th accept
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 255, 0);
    cycle(1'b0, 1'b0, 0, 0);
    chk("fill_strobe", int'(bus.out_valid), 1);
    chk("fill_rain100", int'(bus.out_rain), 100);
    chk("fill_soil0", int'(bus.out_soil), 0);

    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 0, 0);
    cycle(1'b0, 1'b1, 128, 128);
    cycle(1'b0, 1'b0, 0, 0);
    chk("avg32_rain", int'(bus.out_rain), 12);
    chk("avg32_soil", int'(bus.out_soil), 12);

    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 200, 200);
    cycle(1'b0, 1'b0, 0, 0);
    chk("avg200", int'(bus.out_rain), 78);
    cycle(1'b0, 1'b1, 0, 0);
    cycle(1'b0, 1'b0, 0, 0);
    chk("avg150", int'(bus.out_rain), 59);

    // flush with a sample present after two accepts
    cycle(1'b0, 1'b1, 10, 20);
    cycle(1'b0, 1'b1, 30, 40);
    cycle(1'b1, 1'b1, 250, 250);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 100, 60);
    cycle(1'b0, 1'b0, 0, 0);
    chk("post_flush", int'(bus.out_rain), 39);

    // idle into timeout, then recover
    for (int i = 0; i < TMO + 3; i++) cycle(1'b0, 1'b0, 0, 0);
    chk("stale_set", int'(bus.stale), 1);
    cycle(1'b0, 1'b1, 5, 5);
    chk("stale_clr", int'(bus.stale), 0);

    // continuous stream in RUN, then reset mid-stream
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 255, 255);
    cycle(1'b0, 1'b0, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit f;
      bit v;
      f = ($urandom_range(0, 99) < 4);
      v = ($urandom_range(0, 99) < 75);
      if ($urandom_range(0, 99) < 2) begin
        for (int k = 0; k < TMO + 2; k++) cycle(1'b0, 1'b0, 0, 0);
      end
      cycle(f, v, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
